digit_entry_sequencer: RTL
==========================

Name: digit_entry_sequencer

Overview:
Keypad-driven controller that sequences 4-digit HH:MM entry into the digit-setting datapath for either the time or the alarm.
- Walks a cursor LH -> RH -> LM -> RM.
- Validates each keypad digit against 24-hour limits.
- Emits one-cycle per-digit set strobes and the setSignal/alarmSignal mode levels that the digit registers consume.
- Sits between the keypad debouncer/decoder and the digit registers. Issues a commit pulse when all four digits are entered.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles with no accepted key before entry aborts; must be >= 2.
TO_W, 10, width of the timeout counter; must satisfy 2^TO_W >= TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
keyValid  in  1  one-cycle strobe, numPad valid this cycle
numPad  in  4  keypad code; 0-9 digits, 10-15 non-digit
modeSet  in  1  request to start time entry (level sampled in IDLE)
modeAlarm  in  1  request to start alarm entry (level sampled in IDLE)
cancel  in  1  abort current entry
setLH  out  1  one-cycle strobe, write digitOut to left-hour digit
setRH  out  1  one-cycle strobe, write digitOut to right-hour digit
setLM  out  1  one-cycle strobe, write digitOut to left-minute digit
setRM  out  1  one-cycle strobe, write digitOut to right-minute digit
digitOut  out  4  validated digit accompanying any set strobe
setSignal  out  1  level, high while time entry is in progress
alarmSignal  out  1  level, high while alarm entry is in progress
cursor  out  2  digit position awaiting entry: 0=LH, 1=RH, 2=LM, 3=RM
busy  out  1  high in any state other than IDLE
commitTime  out  1  one-cycle pulse, time entry complete
commitAlarm  out  1  one-cycle pulse, alarm entry complete
error  out  1  one-cycle pulse, key rejected
abort  out  1  one-cycle pulse, entry abandoned via cancel or timeout

Behaviour:
- Reset (async): state=IDLE. All outputs 0. Timeout counter=0. Stored LH=0. Mode flag=time.
- States: IDLE, E_LH, E_RH, E_LM, E_RM, COMMIT. cursor = 0,1,2,3 in E_LH..E_RM and 0 in IDLE/COMMIT.
- IDLE:
  - modeSet=1 -> E_LH with setSignal=1.
  - else modeAlarm=1 -> E_LH with alarmSignal=1.
  - Both high: modeSet wins.
  - keyValid is ignored in IDLE.
- setSignal and alarmSignal are registered levels. They are mutually exclusive and held from E_LH through COMMIT inclusive, and cleared on return to IDLE.
- Digit limits:
  - LH: 0-2.
  - RH: 0-9, or 0-3 when stored LH=2.
  - LM: 0-5.
  - RM: 0-9.
  - Codes 10-15 are always invalid.
- Accepted key in cycle N:
  - Cycle N+1: the matching set strobe=1 and digitOut=numPad; state advances to the next position.
  - LH value is stored internally for the RH check.
- Rejected key in cycle N: cycle N+1 error=1. No strobe, state unchanged, timeout counter not cleared.
- E_RM accepted -> COMMIT. COMMIT lasts exactly one cycle with commitTime or commitAlarm=1 per mode, then IDLE.
- cancel in any E_* state: next cycle abort=1 and state -> IDLE. cancel beats a simultaneous keyValid (no strobe). cancel in IDLE or COMMIT is ignored.
- Timeout:
  - Counter increments each cycle in E_* states and clears on an accepted key or on entering E_LH.
  - When it reaches TIMEOUT_CYCLES-1: next cycle abort=1, state -> IDLE.
  - cancel and timeout in the same cycle produce a single abort pulse.
- Mode requests while busy are ignored.
- Already-written digits are not rolled back on abort. Downstream uses commit* to latch.
- Reset mid-entry: immediate IDLE, all strobes and levels drop asynchronously.
- Outputs are registered. At most one of setLH/setRH/setLM/setRM/error/abort/commit* is high per cycle.

Optional Feature:
Macro DIGIT_ENTRY_BACKSPACE_EN.
- Defined:
  - numPad=4'hF with keyValid in E_RH/E_LM/E_RM moves the state back one position next cycle, clears the timeout counter, and emits no strobe and no error.
  - In E_LH, 4'hF is treated like cancel (abort pulse).
- Undefined: 4'hF is an invalid code and produces an error pulse.

Test Plan:
- reset; modeSet=1; keys 1,2,3,4 -> strobes setLH/RH/LM/RM one cycle after each key with digitOut 1,2,3,4; commitTime=1 one cycle after the setRM cycle; setSignal=1 throughout, then 0; busy=0.
- modeAlarm=1; keys 2,4 -> key 2 gives setLH with digitOut=2; key 4 gives error=1 and cursor stays 1; then key 3 gives setRH with digitOut=3.
- modeSet and modeAlarm both high in IDLE -> setSignal=1, alarmSignal=0; key 7 in E_LH -> error=1.
- time entry; after LH=1, cancel and keyValid(5) in the same cycle -> abort=1, no setRH, state IDLE, setSignal=0 next cycle.
- TIMEOUT_CYCLES=8; enter E_LH, no keys -> abort=1 exactly 8 cycles after entry, then IDLE.
- DIGIT_ENTRY_BACKSPACE_EN: keys 1, 4'hF, 2 -> setLH with digitOut=1, cursor returns to 0 with no strobe, then setLH with digitOut=2; without the macro, 4'hF gives error=1.

Source files
------------

// File: rtl/digit_entry_sequencer.sv
// rtl/digit_entry_sequencer.sv - keypad HH:MM entry sequencer feeding the time/alarm digit registers
// Optional macro DIGIT_ENTRY_BACKSPACE_EN: code 4'hF steps the cursor back one digit.
module digit_entry_sequencer #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       keyValid,
   input  logic [3:0] numPad,
   input  logic       modeSet,
   input  logic       modeAlarm,
   input  logic       cancel,
   output logic       setLH,
   output logic       setRH,
   output logic       setLM,
   output logic       setRM,
   output logic [3:0] digitOut,
   output logic       setSignal,
   output logic       alarmSignal,
   output logic [1:0] cursor,
   output logic       busy,
   output logic       commitTime,
   output logic       commitAlarm,
   output logic       error,
   output logic       abort
);
   typedef enum logic [2:0] {IDLE, E_LH, E_RH, E_LM, E_RM, COMMIT} state_t;

   state_t          state, state_n;
   logic            mode_alarm, mode_alarm_n;
   logic [3:0]      lh_q, lh_n;
   logic [TO_W-1:0] cnt, cnt_n;
   logic [3:0]      strobe_n, digit_n;
   logic [1:0]      cursor_n;
   logic            commit_time_n, commit_alarm_n, error_n, abort_n;
   logic            key_ok, timeout, back_key;

   always_comb begin
      state_n        = state;
      mode_alarm_n   = mode_alarm;
      lh_n           = lh_q;
      cnt_n          = '0;
      strobe_n       = 4'b0000;
      digit_n        = 4'd0;
      commit_time_n  = 1'b0;
      commit_alarm_n = 1'b0;
      error_n        = 1'b0;
      abort_n        = 1'b0;
      cursor_n       = 2'd0;

      // 24-hour limits; the right-hour limit depends on the stored left hour
      case (state)
         E_LH:    key_ok = (numPad <= 4'd2);
         E_RH:    key_ok = (lh_q == 4'd2) ? (numPad <= 4'd3) : (numPad <= 4'd9);
         E_LM:    key_ok = (numPad <= 4'd5);
         E_RM:    key_ok = (numPad <= 4'd9);
         default: key_ok = 1'b0;
      endcase

      timeout = (cnt == TO_W'(TIMEOUT_CYCLES - 1));
`ifdef DIGIT_ENTRY_BACKSPACE_EN
      back_key = keyValid && (numPad == 4'hF);
`else
      back_key = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (modeSet) begin
               state_n      = E_LH;
               mode_alarm_n = 1'b0;
            end else if (modeAlarm) begin
               state_n      = E_LH;
               mode_alarm_n = 1'b1;
            end
         end
         COMMIT: begin
            state_n        = IDLE;
            commit_time_n  = !mode_alarm;
            commit_alarm_n = mode_alarm;
         end
         default: begin
            cnt_n = cnt + 1'b1;
            // abandon paths outrank any key arriving in the same cycle
            if (cancel || timeout || (back_key && state == E_LH)) begin
               state_n = IDLE;
               abort_n = 1'b1;
               cnt_n   = '0;
            end else if (back_key) begin
               cnt_n   = '0;
               state_n = (state == E_RH) ? E_LH : (state == E_LM) ? E_RH : E_LM;
            end else if (keyValid && key_ok) begin
               cnt_n   = '0;
               digit_n = numPad;
               case (state)
                  E_LH: begin
                     strobe_n = 4'b1000;
                     lh_n     = numPad;
                     state_n  = E_RH;
                  end
                  E_RH: begin
                     strobe_n = 4'b0100;
                     state_n  = E_LM;
                  end
                  E_LM: begin
                     strobe_n = 4'b0010;
                     state_n  = E_RM;
                  end
                  default: begin
                     strobe_n = 4'b0001;
                     state_n  = COMMIT;
                  end
               endcase
            end else if (keyValid) begin
               error_n = 1'b1;
            end
         end
      endcase

      case (state_n)
         E_RH:    cursor_n = 2'd1;
         E_LM:    cursor_n = 2'd2;
         E_RM:    cursor_n = 2'd3;
         default: cursor_n = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         mode_alarm  <= 1'b0;
         lh_q        <= 4'd0;
         cnt         <= '0;
         setLH       <= 1'b0;
         setRH       <= 1'b0;
         setLM       <= 1'b0;
         setRM       <= 1'b0;
         digitOut    <= 4'd0;
         setSignal   <= 1'b0;
         alarmSignal <= 1'b0;
         cursor      <= 2'd0;
         busy        <= 1'b0;
         commitTime  <= 1'b0;
         commitAlarm <= 1'b0;
         error       <= 1'b0;
         abort       <= 1'b0;
      end else begin
         state       <= state_n;
         mode_alarm  <= mode_alarm_n;
         lh_q        <= lh_n;
         cnt         <= cnt_n;
         setLH       <= strobe_n[3];
         setRH       <= strobe_n[2];
         setLM       <= strobe_n[1];
         setRM       <= strobe_n[0];
         digitOut    <= digit_n;
         setSignal   <= (state_n != IDLE) && !mode_alarm_n;
         alarmSignal <= (state_n != IDLE) && mode_alarm_n;
         cursor      <= cursor_n;
         busy        <= (state_n != IDLE);
         commitTime  <= commit_time_n;
         commitAlarm <= commit_alarm_n;
         error       <= error_n;
         abort       <= abort_n;
      end
   end
endmodule
